// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the multi-address I2C slave engine.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        STRETCH,
        WAIT_STOP
    } state_t;

    localparam int              ADDR_W        = 7;
    localparam logic [ADDR_W-1:0] GEN_CALL_ADDR = 7'h00;

    // Open-drain SDA levels during the acknowledge bit
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_events.sv
// Bus condition detector: remembers the previous SCL/SDA levels and flags
// SCL edges plus START/STOP as registered single-cycle pulses.
module i2c_bus_events (
    input  logic clk,
    input  logic rst,
    input  logic scl_sync,
    input  logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_q;
    logic sda_q;

    // Previous-level registers and edge/condition pulses; SCL must be high on
    // both samples so an SDA change racing an SCL edge is not a START/STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_q     <= scl_sync;
            sda_q     <= sda_sync;
            scl_rise  <= scl_sync & ~scl_q;
            scl_fall  <= ~scl_sync & scl_q;
            start_det <= scl_sync & scl_q & sda_q & ~sda_sync;
            stop_det  <= scl_sync & scl_q & ~sda_q & sda_sync;
        end
    end

endmodule

// File: rtl/i2c_slave_multi.sv
// I2C slave engine answering up to NUM_ADDR table addresses plus an optional
// general call, with FIFO-side push/pop pulses and optional clock stretching.
module i2c_slave_multi
    import i2c_slave_pkg::*;
#(
    parameter int NUM_ADDR = 4,
    parameter int IDX_W    = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scl_sync,
    input  logic                       sda_sync,
    input  logic [NUM_ADDR*ADDR_W-1:0] addr_table,
    input  logic [NUM_ADDR-1:0]        addr_en,
    input  logic                       gen_call_en,
    input  logic                       stretch_en,
    input  logic [7:0]                 tx_data,
    input  logic                       tx_empty,
    output logic                       tx_rd_en,
    input  logic                       rx_full,
    output logic [7:0]                 rx_data,
    output logic                       rx_wr_en,
    output logic [IDX_W-1:0]           match_idx,
    output logic                       gen_call,
    output logic                       busy,
    output logic                       txn_done,
    output logic                       ack_err,
    output logic                       sda_out,
    output logic                       scl_out
);

    logic scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_events u_events (
        .clk       (clk),
        .rst       (rst),
        .scl_sync  (scl_sync),
        .sda_sync  (sda_sync),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic       rw_q, rw_d;

    logic             busy_d, gc_d, sda_d, scl_d;
    logic             rx_wr_d, tx_rd_d, done_d, err_d;
    logic [7:0]       rxd_d;
    logic [IDX_W-1:0] idx_d;

    // Per-entry address comparators against the received 7-bit address
    logic [NUM_ADDR-1:0] hit;
    for (genvar g = 0; g < NUM_ADDR; g++) begin : g_cmp
        assign hit[g] = addr_en[g] && (addr_table[ADDR_W*g +: ADDR_W] == shreg_q[7:1]);
    end

    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic             gc_hit;

    // Priority encode so the lowest matching entry wins; general call only on write
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ADDR - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        gc_hit = gen_call_en && (shreg_q[7:1] == GEN_CALL_ADDR) && !shreg_q[0];
    end

    logic push_rx, load_tx;

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        rw_d     = rw_q;
        busy_d   = busy;
        idx_d    = match_idx;
        gc_d     = gen_call;
        sda_d    = sda_out;
        scl_d    = scl_out;
        rxd_d    = rx_data;
        rx_wr_d  = 1'b0;
        tx_rd_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        push_rx  = 1'b0;
        load_tx  = 1'b0;

        // SCL is held low in STRETCH, so bus conditions there can only be glitches
        if (stop_det && state_q != STRETCH) begin
            state_d = IDLE;
            sda_d   = 1'b1;
            scl_d   = 1'b1;
            busy_d  = 1'b0;
            gc_d    = 1'b0;
            done_d  = busy;
        end else if (start_det && state_q != STRETCH) begin
            state_d  = ADDR;
            bitcnt_d = '0;
            sda_d    = 1'b1;
            scl_d    = 1'b1;
            busy_d   = 1'b0;
            gc_d     = 1'b0;
            done_d   = busy;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_d  = {shreg_q[6:0], sda_sync};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        if (gc_hit || hit_any) begin
                            state_d = ADDR_ACK;
                            sda_d   = ACK;
                            busy_d  = 1'b1;
                            rw_d    = shreg_q[0];
                            gc_d    = gc_hit;
                            idx_d   = gc_hit ? '0 : hit_idx;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            load_tx = 1'b1;
                        end else begin
                            state_d  = RX_BYTE;
                            sda_d    = 1'b1;
                            bitcnt_d = '0;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shreg_d  = {shreg_q[6:0], sda_sync};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        if (!rx_full) begin
                            push_rx = 1'b1;
                        end else if (stretch_en) begin
                            state_d = STRETCH;
                            scl_d   = 1'b0;
                        end else begin
                            state_d = RX_ACK;
                            sda_d   = NACK;
                            err_d   = 1'b1;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_d  = RX_BYTE;
                        sda_d    = 1'b1;
                        bitcnt_d = '0;
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        state_d = TX_ACK;
                        sda_d   = 1'b1;
                    end else if (scl_fall && bitcnt_q != 4'd0) begin
                        shreg_d = {shreg_q[6:0], 1'b1};
                        sda_d   = shreg_q[6];
                    end
                end
                TX_ACK: begin
                    // bitcnt 9 marks "master acknowledged, send another byte"
                    if (scl_rise) begin
                        if (sda_sync == ACK) bitcnt_d = 4'd9;
                        else                 state_d  = WAIT_STOP;
                    end else if (scl_fall && bitcnt_q == 4'd9) begin
                        load_tx = 1'b1;
                    end
                end
                STRETCH: begin
                    if (!rw_q && !rx_full)  push_rx = 1'b1;
                    if (rw_q && !tx_empty)  load_tx = 1'b1;
                end
                IDLE, WAIT_STOP: ;
                default: state_d = IDLE;
            endcase

            if (push_rx) begin
                state_d = RX_ACK;
                rxd_d   = shreg_q;
                rx_wr_d = 1'b1;
                sda_d   = ACK;
                scl_d   = 1'b1;
            end

            if (load_tx) begin
                bitcnt_d = '0;
                scl_d    = 1'b1;
                if (!tx_empty) begin
                    state_d = TX_BYTE;
                    tx_rd_d = 1'b1;
                    shreg_d = tx_data;
                    sda_d   = tx_data[7];
                end else if (stretch_en) begin
                    state_d = STRETCH;
                    scl_d   = 1'b0;
                    sda_d   = 1'b1;
                end else begin
                    // Underflow without stretching: all-ones byte is just a released line
                    state_d = TX_BYTE;
                    shreg_d = 8'hFF;
                    sda_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
        end
    end

    // State and output registers; reset releases both lines immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            rw_q      <= 1'b0;
            busy      <= 1'b0;
            match_idx <= '0;
            gen_call  <= 1'b0;
            sda_out   <= 1'b1;
            scl_out   <= 1'b1;
            rx_data   <= '0;
            rx_wr_en  <= 1'b0;
            tx_rd_en  <= 1'b0;
            txn_done  <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            rw_q      <= rw_d;
            busy      <= busy_d;
            match_idx <= idx_d;
            gen_call  <= gc_d;
            sda_out   <= sda_d;
            scl_out   <= scl_d;
            rx_data   <= rxd_d;
            rx_wr_en  <= rx_wr_d;
            tx_rd_en  <= tx_rd_d;
            txn_done  <= done_d;
            ack_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_multi.sv
// Directed bench for i2c_slave_multi: bit-level master model on a wired-AND bus.
module tb_i2c_slave_multi;

    localparam int NUM_ADDR = 4;
    localparam int IDX_W    = 2;
    localparam int Q        = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1, m_sda = 1'b1;
    logic scl_sync, sda_sync;
    logic [NUM_ADDR*7-1:0] addr_table;
    logic [NUM_ADDR-1:0]   addr_en;
    logic gen_call_en = 1'b0, stretch_en = 1'b0, rx_full = 1'b0;
    logic [7:0] tx_data, rx_data;
    logic tx_empty, tx_rd_en, rx_wr_en;
    logic [IDX_W-1:0] match_idx;
    logic gen_call, busy, txn_done, ack_err, sda_out, scl_out;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    assign scl_sync = m_scl & scl_out;
    assign sda_sync = m_sda & sda_out;

    i2c_slave_multi #(.NUM_ADDR(NUM_ADDR), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .scl_sync(scl_sync), .sda_sync(sda_sync),
        .addr_table(addr_table), .addr_en(addr_en), .gen_call_en(gen_call_en),
        .stretch_en(stretch_en), .tx_data(tx_data), .tx_empty(tx_empty),
        .tx_rd_en(tx_rd_en), .rx_full(rx_full), .rx_data(rx_data),
        .rx_wr_en(rx_wr_en), .match_idx(match_idx), .gen_call(gen_call),
        .busy(busy), .txn_done(txn_done), .ack_err(ack_err),
        .sda_out(sda_out), .scl_out(scl_out)
    );

    // TX FIFO model: first-word-fall-through over an append-only array
    logic [7:0] fifo [0:15];
    int fifo_len = 0;
    int fifo_rd  = 0;
    assign tx_empty = (fifo_rd >= fifo_len);
    assign tx_data  = fifo[fifo_rd[3:0]];

    // Event monitors
    int push_n = 0, pop_n = 0, done_n = 0, err_n = 0, scl_low_n = 0, sda_low_n = 0, both_n = 0;
    logic [7:0] push_log [0:15];
    always @(posedge clk) begin
        if (rx_wr_en) begin
            push_log[push_n[3:0]] <= rx_data;
            push_n <= push_n + 1;
        end
        if (tx_rd_en) begin
            pop_n   <= pop_n + 1;
            fifo_rd <= fifo_rd + 1;
        end
        if (txn_done)             done_n    <= done_n + 1;
        if (ack_err)              err_n     <= err_n + 1;
        if (!scl_out)             scl_low_n <= scl_low_n + 1;
        if (!sda_out)             sda_low_n <= sda_low_n + 1;
        if (rx_wr_en && tx_rd_en) both_n    <= both_n + 1;
    end

    int stretch_max = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; waits out stretching and frees a stalled RX FIFO after 20 cycles
    task automatic clk_bit(input logic b, output logic r);
        int cnt;
        m_sda = b;
        wq(Q);
        m_scl = 1'b1;
        cnt   = 0;
        @(negedge clk);
        while (scl_sync !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (cnt == 20 && rx_full) rx_full = 1'b0;
        end
        if (cnt >= 400) chk("scl_stretch_timeout", cnt, 0);
        if (cnt > stretch_max) stretch_max = cnt;
        wq(Q);
        r     = sda_sync;
        m_scl = 1'b0;
        wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            d[i] = r;
        end
        clk_bit(mack, r);
    endtask

    task automatic do_start;
        m_sda = 1'b1; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic do_stop;
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b1; wq(2*Q);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic       ack, r;
    logic [7:0] d;
    int p0, d0, e0, s0, q0;

    initial begin
        addr_table = {7'h53, 7'h52, 7'h51, 7'h50};
        addr_en    = 4'hF;
        for (int i = 0; i < 16; i++) fifo[i] = 8'h00;

        // Reset state
        rst = 1'b1;
        wq(4);
        chk("rst_sda_out",   sda_out,   1);
        chk("rst_scl_out",   scl_out,   1);
        chk("rst_busy",      busy,      0);
        chk("rst_txn_done",  txn_done,  0);
        chk("rst_ack_err",   ack_err,   0);
        chk("rst_tx_rd_en",  tx_rd_en,  0);
        chk("rst_rx_wr_en",  rx_wr_en,  0);
        chk("rst_rx_data",   rx_data,   0);
        chk("rst_match_idx", match_idx, 0);
        chk("rst_gen_call",  gen_call,  0);
        rst = 1'b0;
        wq(4);

        // Write to 0x52: two data bytes
        p0 = push_n; d0 = done_n;
        do_start;
        write_byte(8'hA4, ack); chk("t1_addr_ack", ack, 0);
        write_byte(8'hA5, ack); chk("t1_d0_ack",   ack, 0);
        write_byte(8'h3C, ack); chk("t1_d1_ack",   ack, 0);
        chk("t1_busy",     busy,      1);
        chk("t1_idx",      match_idx, 2);
        chk("t1_gen_call", gen_call,  0);
        do_stop;
        chk("t1_push_cnt", push_n - p0, 2);
        chk("t1_push0",    push_log[p0],     8'hA5);
        chk("t1_push1",    push_log[p0 + 1], 8'h3C);
        chk("t1_done",     done_n - d0, 1);
        chk("t1_busy_end", busy, 0);

        // Unknown address 0x11
        p0 = push_n; d0 = done_n; s0 = sda_low_n;
        do_start;
        write_byte(8'h22, ack); chk("t2_nack", ack, 1);
        chk("t2_busy", busy, 0);
        write_byte(8'h55, ack);
        do_stop;
        chk("t2_sda_never_low", sda_low_n - s0, 0);
        chk("t2_no_push",       push_n - p0, 0);
        chk("t2_no_done",       done_n - d0, 0);

        // Read from 0x50 with FIFO {0x12, 0x34}
        fifo[fifo_len] = 8'h12; fifo[fifo_len + 1] = 8'h34; fifo_len += 2;
        q0 = pop_n; d0 = done_n;
        do_start;
        write_byte(8'hA1, ack); chk("t3_addr_ack", ack, 0);
        read_byte(1'b0, d);     chk("t3_byte0", d, 8'h12);
        read_byte(1'b1, d);     chk("t3_byte1", d, 8'h34);
        chk("t3_pops",        pop_n - q0, 2);
        chk("t3_sda_release", sda_out, 1);
        do_stop;
        chk("t3_done", done_n - d0, 1);

        // RX full on 2nd data byte, stretching enabled
        stretch_en = 1'b1;
        p0 = push_n; s0 = scl_low_n;
        do_start;
        write_byte(8'hA0, ack); chk("t4a_addr_ack", ack, 0);
        write_byte(8'h11, ack); chk("t4a_d0_ack",   ack, 0);
        rx_full = 1'b1; stretch_max = 0;
        write_byte(8'h22, ack); chk("t4a_d1_ack",   ack, 0);
        chk("t4a_stretch_held", stretch_max >= 20, 1);
        chk("t4a_scl_low",      (scl_low_n - s0) >= 20, 1);
        chk("t4a_push_cnt",     push_n - p0, 2);
        chk("t4a_push1",        push_log[p0 + 1], 8'h22);
        do_stop;

        // RX full on 2nd data byte, no stretching
        stretch_en = 1'b0;
        p0 = push_n; e0 = err_n; s0 = scl_low_n;
        do_start;
        write_byte(8'hA0, ack); chk("t4b_addr_ack", ack, 0);
        write_byte(8'h11, ack); chk("t4b_d0_ack",   ack, 0);
        rx_full = 1'b1;
        write_byte(8'h22, ack); chk("t4b_d1_nack",  ack, 1);
        chk("t4b_ack_err",  err_n - e0, 1);
        chk("t4b_push_cnt", push_n - p0, 1);
        chk("t4b_no_scl_low", scl_low_n - s0, 0);
        rx_full = 1'b0;
        do_stop;

        // Write then repeated-START read, same entry
        fifo[fifo_len] = 8'h5A; fifo_len += 1;
        p0 = push_n; d0 = done_n;
        do_start;
        write_byte(8'hA0, ack); chk("t5_w_ack", ack, 0);
        chk("t5_w_idx", match_idx, 0);
        write_byte(8'h07, ack); chk("t5_d_ack", ack, 0);
        chk("t5_push", push_log[p0], 8'h07);
        do_start;
        chk("t5_restart_done", done_n - d0, 1);
        chk("t5_restart_busy", busy, 0);
        write_byte(8'hA1, ack); chk("t5_r_ack", ack, 0);
        chk("t5_r_idx",  match_idx, 0);
        chk("t5_r_busy", busy, 1);
        read_byte(1'b1, d);     chk("t5_r_byte", d, 8'h5A);
        do_stop;
        chk("t5_done_total", done_n - d0, 2);

        // General call
        gen_call_en = 1'b1;
        do_start;
        write_byte(8'h00, ack); chk("t6_gc_ack", ack, 0);
        chk("t6_gen_call", gen_call,  1);
        chk("t6_idx",      match_idx, 0);
        chk("t6_busy",     busy,      1);
        do_stop;
        chk("t6_gen_call_end", gen_call, 0);
        gen_call_en = 1'b0;

        // Reset while driving the address ACK
        do_start;
        for (int i = 7; i >= 0; i--) clk_bit(((8'hA4 >> i) & 8'h01) != 0, r);
        chk("t7_ack_driven", sda_out, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_rst_sda",  sda_out, 1);
        chk("t7_rst_scl",  scl_out, 1);
        chk("t7_rst_busy", busy,    0);
        rst = 1'b0;
        wq(4);
        do_stop;
        do_start;
        write_byte(8'hA6, ack); chk("t7_after_ack", ack, 0);
        chk("t7_after_idx", match_idx, 3);
        do_stop;

        chk("no_push_pop_overlap", both_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_multi.md
# i2c_slave_multi

Parametrised I2C slave engine serving up to NUM_ADDR independent 7-bit bus addresses, with an optional general-call response and configurable clock stretching. It sits between the synchronised SCL/SDA pins and the TX/RX FIFOs inside the I2C peripheral. It reports which address entry ("channel") a transaction hit, so firmware can demultiplex traffic.

## Interface
- NUM_ADDR, 4: number of address-table entries (1..16).
- IDX_W, $clog2(NUM_ADDR) (min 1): width of match_idx.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- scl_sync  in  1  SCL, already synchronised to clk.
- sda_sync  in  1  SDA, already synchronised to clk.
- addr_table  in  NUM_ADDR*7  entry i = bits [7i+6:7i].
- addr_en  in  NUM_ADDR  per-entry enable.
- gen_call_en  in  1  ACK address 0x00 with write.
- stretch_en  in  1  allow SCL stretching.
- tx_data  in  8  TX FIFO head (first-word-fall-through).
- tx_empty  in  1  TX FIFO empty.
- tx_rd_en  out  1  pop pulse.
- rx_full  in  1  RX FIFO full.
- rx_data  out  8  received byte.
- rx_wr_en  out  1  push pulse.
- match_idx  out  IDX_W  matched entry; valid while busy.
- gen_call  out  1  current transaction is a general call.
- busy  out  1  slave addressed.
- txn_done  out  1  one-cycle pulse at end of an addressed transaction.
- ack_err  out  1  one-cycle pulse on overflow or underflow without stretching.
- sda_out  out  1  open-drain: 0 = pull low, 1 = release.
- scl_out  out  1  open-drain: 0 = pull low, 1 = release.

## Operation
- Event detection uses registered previous SCL/SDA values.
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - SCL rise = sample point; SCL fall = drive point.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, STRETCH, WAIT_STOP.
- IDLE → ADDR on START. ADDR shifts 8 bits MSB first on SCL rises.
- Address match:
  - Compare upper 7 bits against each enabled entry; the lowest matching index wins and sets match_idx.
  - 0x00 with R/W=0 and gen_call_en=1 matches with gen_call=1 and match_idx=0.
  - Match: drive ACK at the SCL fall after bit 8; busy=1.
  - No match: WAIT_STOP, lines released.
- Write (R/W=0):
  - RX_BYTE shifts 8 bits.
  - At the following SCL fall: if rx_full=0, pulse rx_wr_en with rx_data and drive ACK.
  - If rx_full=1 and stretch_en=1: enter STRETCH (scl_out=0) until rx_full=0, then push, ACK, release SCL.
  - If rx_full=1 and stretch_en=0: NACK, drop the byte, pulse ack_err.
- Read (R/W=1):
  - At each byte start (SCL fall after ACK), if tx_empty=0, pulse tx_rd_en and load tx_data.
  - If tx_empty=1 and stretch_en=1: stretch until not empty.
  - If tx_empty=1 and stretch_en=0: send 0xFF and pulse ack_err.
  - Bits are driven MSB first on SCL falls; SDA is released for the master ACK bit.
  - Master ACK (0 sampled at the 9th rise) → next byte. NACK → WAIT_STOP.
- STOP in any state: go to IDLE, release both lines, busy=0. Pulse txn_done if busy was 1.
- Repeated START in any non-IDLE state: go to ADDR. Pulse txn_done if busy was 1; busy drops until the new address matches.
- START/STOP detected while STRETCH holds SCL low is impossible by protocol and is ignored.

## Timing
- Reset values: sda_out=1, scl_out=1, busy=0, txn_done=0, ack_err=0, tx_rd_en=0, rx_wr_en=0, rx_data=0, match_idx=0, gen_call=0.
- Event latency: a detected edge is acted upon one cycle after the sync input changes. sda_out/scl_out change two cycles after the sync-input edge.
- clk must be ≥ 16× SCL rate.
- rx_wr_en and tx_rd_en are single-cycle pulses, never asserted in the same cycle. rx_data is stable from the rx_wr_en cycle until the next push.
- STRETCH release: scl_out=1 the cycle after rx_full/tx_empty deasserts, together with the push/pop pulse.
- Reset mid-transfer releases both lines on the next clock edge.

## Structure
- Package i2c_slave_pkg holds:
  - the state enum;
  - ADDR_W=7 and GEN_CALL_ADDR=7'h00;
  - ACK=1'b0 and NACK=1'b1.
- Sub-module i2c_bus_events: registers SCL/SDA and outputs scl_rise, scl_fall, start_det, stop_det.

## Test plan
- Table {0x50,0x51,0x52,0x53}, all enabled; write 0xA4 (0x52 W), 0xA5, 0x3C, STOP → three ACKs; rx_wr_en pulses with 0xA5 then 0x3C; match_idx=2; one txn_done.
- Address 0x11 W → no ACK (sda_out stays 1), no rx_wr_en, busy=0, no txn_done.
- Read 0xA1 with FIFO {0x12,0x34}; master ACK then NACK → SDA bits 00010010, 00110100; two tx_rd_en pulses; SDA released after NACK.
- rx_full=1 during the 2nd write byte:
  - stretch_en=1: scl_out low until rx_full drops, then push and ACK.
  - stretch_en=0: NACK and one ack_err pulse.
- Write 0xA0, data 0x07, repeated START, 0xA1 read → txn_done on the restart, match_idx=0 in both phases. Separately, 0x00 with gen_call_en=1 → ACK, gen_call=1.
- rst asserted while sda_out=0 mid-ACK → next cycle sda_out=1, scl_out=1, busy=0; a later START is decoded normally.
